// File: rtl/rcv_byte_assembler.sv
// ----------------------------------------------------------------------------
// rcv_byte_assembler
//
// Purpose:
//   Receive-side byte assembler for an NRZI, bit-stuffed serial line.
//   On each shift_strobe it NRZI-decodes the line bit and removes the zero that
//   the transmitter stuffs after six consecutive ones. It shifts accepted bits
//   in LSB first and presents each completed byte on rcv_data. A one-cycle
//   byte_received pulse marks each new byte. An end-of-packet that arrives
//   with a partial byte pending raises align_error.
//
// Configuration:
//   RCV_STUFF_CHECK_EN  When defined, a decoded 1 where a stuffed 0 was
//                       expected pulses stuff_error and locks the receiver in
//                       IDLE until rcv_enable falls and rises again. When
//                       undefined, stuff_error is tied low and the stuffed bit
//                       is dropped whatever its value.
//
// Ports:
//   clk            in   system clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   shift_strobe   in   one-cycle bit-sample pulse
//   d_orig         in   synchronized raw NRZI line bit
//   eop            in   synchronized end-of-packet, one or more cycles high
//   rcv_enable     in   high while a packet is being received
//   rcv_data       out  [7:0] last complete byte, first received bit in bit 0
//   byte_received  out  one-cycle pulse when rcv_data updates
//   stuff_error    out  one-cycle pulse on a bit-stuffing violation
//   align_error    out  one-cycle pulse on eop with a partial byte pending
//   o_dbg_state    out  [1:0] FSM state (0 IDLE, 1 RECEIVE, 2 UNSTUFF)
//
// Handshake: there is no back-pressure. shift_strobe is a qualifier that is
// valid for one cycle. byte_received is a one-cycle valid pulse. rcv_data
// holds its value until the next pulse.
// ----------------------------------------------------------------------------
module rcv_byte_assembler (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       shift_strobe,
    input  logic       d_orig,
    input  logic       eop,
    input  logic       rcv_enable,
    output logic [7:0] rcv_data,
    output logic       byte_received,
    output logic       stuff_error,
    output logic       align_error,
    output logic [1:0] o_dbg_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECEIVE = 2'd1;
    localparam logic [1:0] ST_UNSTUFF = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_prev_bit;
    logic [2:0] r_ones_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_rcv_data;
    logic       r_byte_received;
    logic       r_align_error;

    logic       w_dec_bit;
    logic       w_accept;
    logic       w_discard;
    logic       w_byte_done;
    logic       w_align_err;
    logic       w_stuff_err;
    logic       w_lock;

    // An unchanged line level decodes as 1. A transition decodes as 0.
    assign w_dec_bit = (d_orig == r_prev_bit);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        if (!rcv_enable || eop) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_lock) w_next_state = ST_RECEIVE;
                end
                ST_RECEIVE: begin
                    // The sixth consecutive 1 is kept. The bit after it is the stuffed one.
                    if (w_accept && w_dec_bit && (r_ones_cnt == 3'd5))
                        w_next_state = ST_UNSTUFF;
                end
                ST_UNSTUFF: begin
                    if (w_discard) w_next_state = w_stuff_err ? ST_IDLE : ST_RECEIVE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // ---------------- output / control logic ----------------
    // eop wins over a coincident strobe, so that strobe is neither shifted nor discarded.
    always_comb begin
        w_accept    = 1'b0;
        w_discard   = 1'b0;
        w_byte_done = 1'b0;
        w_align_err = 1'b0;
        w_stuff_err = 1'b0;
        if ((r_state != ST_IDLE) && rcv_enable) begin
            if (eop) begin
                w_align_err = (r_bit_cnt != 3'd0);
            end else if (shift_strobe) begin
                if (r_state == ST_RECEIVE) begin
                    w_accept    = 1'b1;
                    w_byte_done = (r_bit_cnt == 3'd7);
                end else if (r_state == ST_UNSTUFF) begin
                    w_discard = 1'b1;
`ifdef RCV_STUFF_CHECK_EN
                    w_stuff_err = w_dec_bit;
`endif
                end
            end
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_prev_bit      <= 1'b1;
            r_ones_cnt      <= 3'd0;
            r_bit_cnt       <= 3'd0;
            r_shift         <= 8'h00;
            r_rcv_data      <= 8'h00;
            r_byte_received <= 1'b0;
            r_align_error   <= 1'b0;
        end else begin
            // The NRZI reference tracks the line on every strobe, even when idle.
            if (shift_strobe) r_prev_bit <= d_orig;
            r_byte_received <= w_byte_done;
            r_align_error   <= w_align_err;
            if (w_next_state == ST_IDLE) begin
                r_ones_cnt <= 3'd0;
                r_bit_cnt  <= 3'd0;
                r_shift    <= 8'h00;
            end else if (w_accept) begin
                r_shift    <= {w_dec_bit, r_shift[7:1]};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                r_ones_cnt <= w_dec_bit ? (r_ones_cnt + 3'd1) : 3'd0;
                if (w_byte_done) r_rcv_data <= {w_dec_bit, r_shift[7:1]};
            end else if (w_discard) begin
                r_ones_cnt <= 3'd0;
            end
        end
    end

`ifdef RCV_STUFF_CHECK_EN
    logic r_stuff_error;
    logic r_lock;

    // After a violation the receiver stays in IDLE until rcv_enable is deasserted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stuff_error <= 1'b0;
            r_lock        <= 1'b0;
        end else begin
            r_stuff_error <= w_stuff_err;
            if (!rcv_enable)      r_lock <= 1'b0;
            else if (w_stuff_err) r_lock <= 1'b1;
        end
    end

    assign w_lock      = r_lock;
    assign stuff_error = r_stuff_error;
`else
    assign w_lock      = 1'b0;
    assign stuff_error = 1'b0;
`endif

    assign rcv_data      = r_rcv_data;
    assign byte_received = r_byte_received;
    assign align_error   = r_align_error;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rcv_byte_assembler.sv
module tb_rcv_byte_assembler;

  logic       clk;
  logic       n_rst;
  logic       shift_strobe;
  logic       d_orig;
  logic       eop;
  logic       rcv_enable;
  logic [7:0] rcv_data;
  logic       byte_received;
  logic       stuff_error;
  logic       align_error;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // pulse monitors (count high cycles, so a stretched pulse shows up)
  int n_byte  = 0;
  int n_stuff = 0;
  int n_align = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  logic line;     // current NRZI line level driven by the bench
  int   tb_ones;  // encoder-side run of consecutive 1s for stuffing

  rcv_byte_assembler dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .shift_strobe  (shift_strobe),
    .d_orig        (d_orig),
    .eop           (eop),
    .rcv_enable    (rcv_enable),
    .rcv_data      (rcv_data),
    .byte_received (byte_received),
    .stuff_error   (stuff_error),
    .align_error   (align_error),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (n_rst) begin
      if (byte_received) begin
        n_byte = n_byte + 1;
        got_q.push_back(rcv_data);
      end
      if (stuff_error) n_stuff = n_stuff + 1;
      if (align_error) n_align = n_align + 1;
    end
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks = n_checks + 1;
    if (obs !== expv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw decoded bit onto the line: 1 keeps the level, 0 toggles it.
  task automatic send_bit(input logic b);
    @(posedge clk);
    #1;
    if (!b) line = ~line;
    d_orig       = line;
    shift_strobe = 1'b1;
    @(posedge clk);
    #1;
    shift_strobe = 1'b0;
  endtask

  // Data bit with transmitter-side stuffing after six 1s.
  task automatic send_data_bit(input logic b);
    send_bit(b);
    tb_ones = b ? tb_ones + 1 : 0;
    if (tb_ones == 6) begin
      send_bit(1'b0);
      tb_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_data_bit(b[i]);
  endtask

  task automatic pulse_eop();
    @(posedge clk);
    #1;
    eop = 1'b1;
    @(posedge clk);
    #1;
    eop = 1'b0;
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    line  = 1'b1;
    d_orig = 1'b1;
    wait_cycles(2);
    n_rst = 1'b1;
    tb_ones = 0;
  endtask

  // ---------------- stimulus ----------------
  int         b0, s0, a0;
  logic [7:0] v;
  logic [1:0] exp_state;
  int         exp_stuff;

  initial begin
    shift_strobe = 1'b0;
    eop          = 1'b0;
    rcv_enable   = 1'b0;
    d_orig       = 1'b1;
    line         = 1'b1;
    tb_ones      = 0;
    n_rst        = 1'b1;
    #2;
    apply_reset();

    // reset values
    check_eq("rst_rcv_data", rcv_data, 8'h00);
    check_eq("rst_byte_received", byte_received, 1'b0);
    check_eq("rst_stuff_error", stuff_error, 1'b0);
    check_eq("rst_align_error", align_error, 1'b0);
    check_eq("rst_state", dbg_state, 2'd0);

    // 0xA5, pulse timing after the 8th strobe
    rcv_enable = 1'b1;
    wait_cycles(2);
    check_eq("enable_state", dbg_state, 2'd1);
    b0 = n_byte;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    check_eq("a5_pulse_edge", byte_received, 1'b1);
    check_eq("a5_data", rcv_data, 8'hA5);
    wait_cycles(1);
    check_eq("a5_pulse_width", byte_received, 1'b0);
    check_eq("a5_count", n_byte - b0, 1);

    // 0xFF, 0x00 with a stuffed zero after six 1s
    b0 = n_byte; s0 = n_stuff;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    send_byte(8'hFF);
    check_eq("ff_data", rcv_data, 8'hFF);
    send_byte(8'h00);
    check_eq("00_data", rcv_data, 8'h00);
    wait_cycles(3);
    check_eq("ff00_count", n_byte - b0, 2);
    check_eq("ff00_no_stuff_err", n_stuff - s0, 0);

    // seven raw consecutive 1s
    b0 = n_byte; s0 = n_stuff;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    wait_cycles(3);
`ifdef RCV_STUFF_CHECK_EN
    exp_stuff = 1;
    exp_state = 2'd0;
`else
    exp_stuff = 0;
    exp_state = 2'd1;
`endif
    check_eq("seven_ones_stuff_err", n_stuff - s0, exp_stuff);
    check_eq("seven_ones_no_byte", n_byte - b0, 0);
    check_eq("seven_ones_state", dbg_state, exp_state);
    check_eq("seven_ones_stuff_low", stuff_error, 1'b0);

    // eop after a full byte, then after 3 bits
    rcv_enable = 1'b0;
    wait_cycles(2);
    rcv_enable = 1'b1;
    tb_ones = 0;
    wait_cycles(2);
    a0 = n_align;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A);
    pulse_eop();
    wait_cycles(3);
    check_eq("eop_full_no_align", n_align - a0, 0);
    a0 = n_align;
    send_data_bit(1'b1);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    pulse_eop();
    check_eq("eop_partial_align_edge", align_error, 1'b1);
    wait_cycles(3);
    check_eq("eop_partial_align_count", n_align - a0, 1);
    check_eq("eop_partial_data_held", rcv_data, 8'h5A);

    // eop coincident with the 8th strobe of 0x96
    tb_ones = 0;
    b0 = n_byte; a0 = n_align;
    v = 8'h96;
    for (int i = 0; i < 7; i++) send_data_bit(v[i]);
    @(posedge clk);
    #1;
    if (!v[7]) line = ~line;
    d_orig       = line;
    shift_strobe = 1'b1;
    eop          = 1'b1;
    @(posedge clk);
    #1;
    shift_strobe = 1'b0;
    eop          = 1'b0;
    check_eq("eop8_state_idle", dbg_state, 2'd0);
    wait_cycles(3);
    check_eq("eop8_no_byte", n_byte - b0, 0);
    check_eq("eop8_align", n_align - a0, 1);
    check_eq("eop8_data_held", rcv_data, 8'h5A);

    // reset mid-byte, then 0x3C
    tb_ones = 0;
    b0 = n_byte; a0 = n_align; s0 = n_stuff;
    for (int i = 0; i < 5; i++) send_data_bit(1'(i % 2));
    apply_reset();
    check_eq("midrst_data_cleared", rcv_data, 8'h00);
    wait_cycles(2);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    wait_cycles(3);
    check_eq("midrst_byte_count", n_byte - b0, 1);
    check_eq("midrst_data", rcv_data, 8'h3C);
    check_eq("midrst_no_align", n_align - a0, 0);
    check_eq("midrst_no_stuff", n_stuff - s0, 0);

    // strobes while disabled: no pulses, NRZI reference still tracks the line
    rcv_enable = 1'b0;
    wait_cycles(2);
    b0 = n_byte; a0 = n_align; s0 = n_stuff;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_cycles(2);
    check_eq("idle_no_byte", n_byte - b0, 0);
    check_eq("idle_no_align", n_align - a0, 0);
    check_eq("idle_no_stuff", n_stuff - s0, 0);
    check_eq("idle_state", dbg_state, 2'd0);
    rcv_enable = 1'b1;
    tb_ones = 0;
    wait_cycles(2);
    exp_q.push_back(8'h81);
    send_byte(8'h81);
    wait_cycles(2);
    check_eq("after_idle_data", rcv_data, 8'h81);

    // scoreboard
    check_eq("byte_total", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("byte_%0d", i),
               (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD,
               {24'h0, exp_q[i]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rcv_byte_assembler.md
RCV_BYTE_ASSEMBLER -- requirements
Module: rcv_byte_assembler

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all state SHALL be registered on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 shift_strobe  input  1  one-cycle pulse marking the bit-sample point.
REQ-005 d_orig  input  1  synchronized raw NRZI line bit, sampled only when shift_strobe=1.
REQ-006 eop  input  1  synchronized end-of-packet indication, one or more cycles high.
REQ-007 rcv_enable  input  1  high while a packet is being received; low means idle.
REQ-008 rcv_data  output  8  last complete byte, LSB received first.
REQ-009 byte_received  output  1  one-cycle pulse when rcv_data is updated.
REQ-010 stuff_error  output  1  one-cycle pulse on a bit-stuffing violation.
REQ-011 align_error  output  1  one-cycle pulse when eop arrives with a partial byte.

Function
REQ-012 NRZI decode SHALL run on every shift_strobe, including when rcv_enable=0: decoded bit = 1 if d_orig equals the previous line bit, else 0; previous line bit SHALL be updated to d_orig.
REQ-013 A 3-bit ones counter SHALL count consecutive decoded 1s; it SHALL clear on a decoded 0 and on rcv_enable=0.
REQ-014 When the ones counter is 6, the next decoded bit SHALL be discarded (not shifted); the ones counter SHALL then clear.
REQ-015 Accepted bits SHALL shift into an 8-bit register from the MSB side (shift right), so the first bit received ends in bit 0.
REQ-016 A 3-bit bit counter SHALL count accepted bits; on the 8th accepted bit the full byte SHALL load into rcv_data and the counter SHALL wrap to 0.
REQ-017 byte_received SHALL assert for exactly one cycle, on the cycle after the strobe that completes the byte; rcv_data SHALL be valid on that cycle and SHALL hold until the next completed byte.
REQ-018 States: IDLE (rcv_enable=0, no counting), RECEIVE (accepting bits), UNSTUFF (next strobe discarded); IDLE->RECEIVE on rcv_enable=1; RECEIVE->UNSTUFF when ones counter reaches 6; UNSTUFF->RECEIVE on the next strobe; any state->IDLE on eop or on rcv_enable=0.
REQ-019 On eop with bit counter nonzero, align_error SHALL pulse for one cycle; with bit counter zero, no error SHALL be flagged.
REQ-020 eop and shift_strobe in the same cycle: eop SHALL take priority and that strobe SHALL not be shifted; the NRZI previous-bit register SHALL still update.
REQ-021 Entering IDLE SHALL clear the bit counter, the ones counter and the shift register; rcv_data SHALL be retained.
REQ-022 A strobe while rcv_enable=0 SHALL never produce byte_received, stuff_error or align_error.

Reset
REQ-023 On n_rst=0: state=IDLE; rcv_data=8'h00; byte_received=0; stuff_error=0; align_error=0; counters=0; shift register=0; previous line bit=1 (idle J).
REQ-024 Reset asserted mid-byte SHALL discard the partial byte with no error pulse.

Configuration
REQ-025 Macro RCV_STUFF_CHECK_EN defined: a decoded 1 in the UNSTUFF position SHALL pulse stuff_error for one cycle and force IDLE until rcv_enable falls and rises again.
REQ-026 Macro RCV_STUFF_CHECK_EN undefined: stuff_error SHALL be tied to 0; the UNSTUFF bit SHALL be discarded regardless of its value and reception SHALL continue.

Verification
REQ-027 Reset, rcv_enable=1, NRZI-encoded 0xA5 over 8 strobes -> rcv_data=8'hA5, byte_received high exactly one cycle after the 8th strobe.
REQ-028 Send 0xFF, 0x00 with the stuffed 0 inserted after six 1s -> rcv_data 8'hFF then 8'h00, two byte_received pulses, stuff_error never high.
REQ-029 Seven consecutive decoded 1s with RCV_STUFF_CHECK_EN defined -> stuff_error one-cycle pulse, no byte_received; macro undefined -> stuff_error stays 0.
REQ-030 eop after 3 bits of a byte -> align_error one-cycle pulse, rcv_data unchanged; eop after a full byte -> no align_error.
REQ-031 eop coincident with the 8th strobe -> no byte_received, align_error pulses, state IDLE.
REQ-032 n_rst asserted after 5 bits, then released and a full 0x3C sent -> only 8'h3C received, no error pulses.
